// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory cacheline port between the icache and dcache.
//
// Whole-line transactions are serialised. Each response is routed only to the cache
// that owns the current transaction. FSM: IDLE -> I_BUSY/D_BUSY -> DONE -> IDLE.
// DONE is a one-cycle gap so that a cache can drop its request before it is re-arbitrated.
//
// Parameters:
//   LINE_WIDTH  cacheline width in bits
//   ADDR_WIDTH  physical address width
//   RR_EN       0: fixed priority (dcache wins ties); 1: round-robin on ties
//
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   i_read, i_address              icache line read request
//   i_rdata, i_resp                icache return data / completion pulse
//   d_read, d_write, d_address,
//   d_wdata                        dcache request (read+write together is a write)
//   d_rdata, d_resp                dcache return data / completion pulse
//   m_read, m_write, m_address,
//   m_wdata                        request to the cacheline adaptor
//   m_rdata, m_resp                adaptor return data / completion
//
// Optional build macro PMEM_ARB_PERF_CNT_EN adds the saturating 32-bit counters
//   i_grant_cnt, d_grant_cnt and conflict_cnt.

module pmem_arbiter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          RR_EN      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  m_read,
    output logic                  m_write,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [LINE_WIDTH-1:0] m_wdata,
    input  logic [LINE_WIDTH-1:0] m_rdata,
    input  logic                  m_resp
`ifdef PMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]           i_grant_cnt,
    output logic [31:0]           d_grant_cnt,
    output logic [31:0]           conflict_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StDone} state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;  // 1: dcache was granted last
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [LINE_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                  req_is_write_q, req_is_write_d;

    logic i_req, d_req;
    logic grant_i, grant_d;
    logic i_busy, d_busy, busy;

    assign i_req  = i_read;
    assign d_req  = d_read | d_write;
    assign i_busy = (state_q == StIBusy);
    assign d_busy = (state_q == StDBusy);
    assign busy   = i_busy | d_busy;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        req_is_write_d = req_is_write_q;
        grant_i        = 1'b0;
        grant_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_req && d_req) begin
                    // On a tie round-robin favours whoever did not go last.
                    if (RR_EN && last_grant_q) grant_i = 1'b1;
                    else                       grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end

                if (grant_i) begin
                    state_d        = StIBusy;
                    last_grant_d   = 1'b0;
                    req_addr_d     = i_address;
                    req_wdata_d    = '0;
                    req_is_write_d = 1'b0;
                end else if (grant_d) begin
                    state_d        = StDBusy;
                    last_grant_d   = 1'b1;
                    req_addr_d     = d_address;
                    req_wdata_d    = d_wdata;
                    req_is_write_d = d_write;
                end
            end
            StIBusy, StDBusy: begin
                if (m_resp) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b1;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_is_write_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            req_is_write_q <= req_is_write_d;
        end
    end

    // Adaptor side is a pure function of registered state.
    assign m_read    = busy & ~req_is_write_q;
    assign m_write   = busy & req_is_write_q;
    assign m_address = busy ? req_addr_q : '0;
    assign m_wdata   = busy ? req_wdata_q : '0;

    // A response arriving while reset is asserted is dropped.
    assign i_resp  = i_busy & m_resp & ~rst;
    assign d_resp  = d_busy & m_resp & ~rst;
    assign i_rdata = i_resp ? m_rdata : '0;
    assign d_rdata = d_resp ? m_rdata : '0;

`ifdef PMEM_ARB_PERF_CNT_EN
    logic waiting;

    // A cache waits when it requests but neither owns nor is being granted the port.
    assign waiting = (i_req & ~(i_busy | grant_i)) | (d_req & ~(d_busy | grant_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant_i && i_grant_cnt != 32'hFFFF_FFFF) i_grant_cnt <= i_grant_cnt + 32'd1;
            if (grant_d && d_grant_cnt != 32'hFFFF_FFFF) d_grant_cnt <= d_grant_cnt + 32'd1;
            if (waiting && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: one fixed-priority and one round-robin instance
// share the same stimulus; each scenario checks the instance it targets.

module tb_pmem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, m_resp;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] d_wdata, m_rdata;

    // f_*: fixed-priority instance, r_*: round-robin instance
    logic [LW-1:0] f_i_rdata, f_d_rdata, f_m_wdata, r_i_rdata, r_d_rdata, r_m_wdata;
    logic          f_i_resp, f_d_resp, f_m_read, f_m_write;
    logic          r_i_resp, r_d_resp, r_m_read, r_m_write;
    logic [AW-1:0] f_m_address, r_m_address;
`ifdef PMEM_ARB_PERF_CNT_EN
    logic [31:0]   f_i_cnt, f_d_cnt, f_c_cnt, r_i_cnt, r_d_cnt, r_c_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int iwait  = 0;
    int budget;
    logic [AW-1:0] exp_addr;

    always #5 clk = ~clk;

    pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_EN(1'b0)) u_fixed (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(f_i_rdata), .i_resp(f_i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(f_d_rdata), .d_resp(f_d_resp),
        .m_read(f_m_read), .m_write(f_m_write), .m_address(f_m_address), .m_wdata(f_m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
`ifdef PMEM_ARB_PERF_CNT_EN
        , .i_grant_cnt(f_i_cnt), .d_grant_cnt(f_d_cnt), .conflict_cnt(f_c_cnt)
`endif
    );

    pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(r_i_rdata), .i_resp(r_i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(r_d_rdata), .d_resp(r_d_resp),
        .m_read(r_m_read), .m_write(r_m_write), .m_address(r_m_address), .m_wdata(r_m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
`ifdef PMEM_ARB_PERF_CNT_EN
        , .i_grant_cnt(r_i_cnt), .d_grant_cnt(r_d_cnt), .conflict_cnt(r_c_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_resp = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0; m_rdata = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state; m_resp in IDLE is ignored
        do_reset();
        m_resp = 1'b1;
        m_rdata = {LW{1'b1}};
        @(negedge clk);
        chk("rst_m_read", f_m_read, 1'b0);
        chk("rst_m_write", f_m_write, 1'b0);
        chk("rst_m_address", f_m_address, '0);
        chk("rst_m_wdata", f_m_wdata, '0);
        chk("idle_mresp_i_resp", f_i_resp, 1'b0);
        chk("idle_mresp_d_resp", f_d_resp, 1'b0);
        chk("idle_mresp_i_rdata", f_i_rdata, '0);
        chk("idle_mresp_d_rdata", f_d_rdata, '0);
        next();
        m_resp = 1'b0;

        // ---------------- single icache read
        do_reset();
        i_read = 1'b1; i_address = 32'h60;                          // cycle 1
        @(negedge clk);
        chk("t1_c1_m_read", f_m_read, 1'b0);
        next();                                                      // cycle 2
        @(negedge clk);
        chk("t1_c2_m_read", f_m_read, 1'b1);
        chk("t1_c2_m_write", f_m_write, 1'b0);
        chk("t1_c2_m_address", f_m_address, 32'h60);
        for (int c = 3; c <= 5; c++) begin
            next();
            @(negedge clk);
            chk("t1_busy_m_read", f_m_read, 1'b1);
            chk("t1_busy_d_resp", f_d_resp, 1'b0);
        end
        next();                                                      // cycle 6
        m_resp = 1'b1; m_rdata = {32{8'hA5}};
        @(negedge clk);
        chk("t1_c6_i_resp", f_i_resp, 1'b1);
        chk("t1_c6_i_rdata", f_i_rdata, {32{8'hA5}});
        chk("t1_c6_d_resp", f_d_resp, 1'b0);
        chk("t1_c6_d_rdata", f_d_rdata, '0);
        next();                                                      // cycle 7 (DONE)
        m_resp = 1'b0; i_read = 1'b0;
        @(negedge clk);
        chk("t1_c7_m_read", f_m_read, 1'b0);
        chk("t1_c7_i_resp", f_i_resp, 1'b0);

        // ---------------- simultaneous requests, fixed priority
        do_reset();
        iwait = 0;
        i_read = 1'b1; i_address = 32'h100;                         // cycle 1
        d_write = 1'b1; d_address = 32'h200; d_wdata = {8{32'hDEADBEEF}};
        @(negedge clk);
        if (i_read && !f_m_read) iwait++;
        chk("t2_c1_m_write", f_m_write, 1'b0);
        next();                                                      // cycle 2
        @(negedge clk);
        if (i_read && !f_m_read) iwait++;
        chk("t2_c2_m_write", f_m_write, 1'b1);
        chk("t2_c2_m_read", f_m_read, 1'b0);
        chk("t2_c2_m_address", f_m_address, 32'h200);
        chk("t2_c2_m_wdata", f_m_wdata, {8{32'hDEADBEEF}});
        chk("t2_rr_first_tie_m_read", r_m_read, 1'b1);
        chk("t2_rr_first_tie_addr", r_m_address, 32'h100);
        next();                                                      // cycle 3
        m_resp = 1'b1; m_rdata = {16{16'h5A5A}};
        @(negedge clk);
        if (i_read && !f_m_read) iwait++;
        chk("t2_c3_d_resp", f_d_resp, 1'b1);
        chk("t2_c3_i_resp", f_i_resp, 1'b0);
        next();                                                      // cycle 4 (DONE)
        m_resp = 1'b0; d_write = 1'b0;
        @(negedge clk);
        if (i_read && !f_m_read) iwait++;
        chk("t2_c4_m_write", f_m_write, 1'b0);
        chk("t2_c4_m_read", f_m_read, 1'b0);
        chk("t2_c4_d_resp", f_d_resp, 1'b0);
        next();                                                      // cycle 5 (IDLE)
        @(negedge clk);
        if (i_read && !f_m_read) iwait++;
        chk("t2_c5_m_read", f_m_read, 1'b0);
        next();                                                      // cycle 6
        @(negedge clk);
        if (i_read && !f_m_read) iwait++;
        chk("t2_c6_m_read", f_m_read, 1'b1);
        chk("t2_c6_m_address", f_m_address, 32'h100);
        chk("t2_c6_m_wdata", f_m_wdata, '0);
        next();                                                      // cycle 7
        m_resp = 1'b1; m_rdata = {8{32'h1234_5678}};
        @(negedge clk);
        chk("t2_c7_i_resp", f_i_resp, 1'b1);
        chk("t2_c7_i_rdata", f_i_rdata, {8{32'h1234_5678}});
        chk("t2_c7_d_resp", f_d_resp, 1'b0);
        next();                                                      // cycle 8
        m_resp = 1'b0; i_read = 1'b0;
        @(negedge clk);
`ifdef PMEM_ARB_PERF_CNT_EN
        chk("t2_d_grant_cnt", f_d_cnt, 32'd1);
        chk("t2_i_grant_cnt", f_i_cnt, 32'd1);
        // the IDLE cycle in which icache is finally granted is not a wait
        chk("t2_conflict_cnt", f_c_cnt, iwait - 1);
`endif

        // ---------------- round-robin, both requesting continuously
        do_reset();
        i_read = 1'b1; i_address = 32'h100;
        d_read = 1'b1; d_address = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
            budget = 0;
            @(negedge clk);
            while (!r_m_read && budget < 8) begin
                next();
                @(negedge clk);
                budget++;
            end
            chk("t3_grant_seen", r_m_read, 1'b1);
            chk("t3_grant_addr", r_m_address, exp_addr);
            next();
            m_resp = 1'b1; m_rdata = LW'(k + 1);
            @(negedge clk);
            chk("t3_i_resp", r_i_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("t3_d_resp", r_d_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
            next();
            m_resp = 1'b0;
        end
        i_read = 1'b0; d_read = 1'b0;

        // ---------------- request dropped mid-transaction
        do_reset();
        d_read = 1'b1; d_address = 32'h300;                         // cycle 1
        next();                                                      // cycle 2
        @(negedge clk);
        chk("t4_c2_m_read", f_m_read, 1'b1);
        chk("t4_c2_m_address", f_m_address, 32'h300);
        for (int c = 3; c <= 4; c++) begin
            next();
            d_read = 1'b0;
            @(negedge clk);
            chk("t4_drop_m_read", f_m_read, 1'b1);
            chk("t4_drop_d_resp", f_d_resp, 1'b0);
        end
        next();                                                      // cycle 5
        m_resp = 1'b1; m_rdata = {4{64'hCAFE_F00D_0BAD_BEEF}};
        @(negedge clk);
        chk("t4_c5_d_resp", f_d_resp, 1'b1);
        chk("t4_c5_d_rdata", f_d_rdata, {4{64'hCAFE_F00D_0BAD_BEEF}});
        next();                                                      // cycle 6
        m_resp = 1'b0;
        @(negedge clk);
        chk("t4_c6_d_resp", f_d_resp, 1'b0);
        chk("t4_c6_m_read", f_m_read, 1'b0);

        // ---------------- reset while I_BUSY (round-robin instance)
        do_reset();
        i_read = 1'b1; i_address = 32'h40;                          // cycle 1
        next();                                                      // cycle 2
        @(negedge clk);
        chk("t5_c2_m_read", r_m_read, 1'b1);
        next();                                                      // cycle 2 drive
        rst = 1'b1;
        @(negedge clk);
        next();                                                      // cycle 3
        rst = 1'b0; i_read = 1'b0; m_resp = 1'b1; m_rdata = {LW{1'b1}};
        @(negedge clk);
        chk("t5_after_rst_m_read", r_m_read, 1'b0);
        chk("t5_after_rst_i_resp", r_i_resp, 1'b0);
        chk("t5_after_rst_i_rdata", r_i_rdata, '0);
        next();                                                      // cycle 4: tie
        m_resp = 1'b0;
        i_read = 1'b1; i_address = 32'h80;
        d_read = 1'b1; d_address = 32'h90;
        next();                                                      // cycle 5
        @(negedge clk);
        chk("t5_tie_m_read", r_m_read, 1'b1);
        chk("t5_tie_addr", r_m_address, 32'h80);
        next();
        m_resp = 1'b1; m_rdata = LW'(32'h77);
        @(negedge clk);
        chk("t5_tie_i_resp", r_i_resp, 1'b1);
        chk("t5_tie_d_resp", r_d_resp, 1'b0);
        next();
        m_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
